// File: rtl/mdl_abspgcntr_pkg.sv
// -----------------------------------------------------------------------------
// mdl_abspgcntr_pkg
// Shared constants for the bit-serial absolute page counter of the 005297
// bubble controller: page range, absolute->relative mapping constants and
// the ROT20 slot indices at which the serial machinery acts.
// -----------------------------------------------------------------------------
package mdl_abspgcntr_pkg;

    // Page geometry.
    localparam int PGMAX          = 2052;                // highest valid absolute page, wrap point
    localparam int RELOFS         = 1299;                // relative page of absolute page 0
    localparam int ABS_GTE_THRESH = PGMAX - RELOFS + 1;  // 754: first abs page that maps to rel 0
    localparam int PG_W           = 12;                  // serial word width
    localparam int ROT_W          = 20;                  // slots per ROT20 frame

    // 12-bit constants streamed LSB-first by slot.
    localparam logic [PG_W-1:0] K_REL_LO = PG_W'(RELOFS);                       // 1299
    localparam logic [PG_W-1:0] K_REL_HI = PG_W'((2**PG_W) - ABS_GTE_THRESH);   // 3342 = -754 mod 4096
    localparam logic [PG_W-1:0] C_GTE    = PG_W'(ABS_GTE_THRESH);               // 754
    localparam logic [PG_W-1:0] C_MAX    = PG_W'(PGMAX);                        // 2052

    // Slot indices.
    localparam int SLOT_LSB   = 0;   // first serial bit
    localparam int SLOT_MSB   = 11;  // last serial bit
    localparam int SLOT_LATCH = 12;  // flags latched from the running comparators
    localparam int SLOT_CLR   = 19;  // frame bookkeeping: arm increment, reset comparators

    // Bit k of a 12-bit constant, selected by the active-low one-hot slot
    // vector; slots 12-19 yield 0.
    function automatic logic slot_const_bit(input logic [ROT_W-1:0] rot_n,
                                            input logic [PG_W-1:0]  konst);
        return |(~rot_n & {{(ROT_W-PG_W){1'b0}}, konst});
    endfunction

endpackage

// File: rtl/mdl_abspgcntr_fa.sv
// -----------------------------------------------------------------------------
// mdl_abspgcntr_fa
// One-bit full adder cell, used as the serial adder stage of the
// absolute->relative page conversion.
// Ports:
//   i_a, i_b, i_cin  addend bits and carry in
//   o_sum, o_cout    sum bit and carry out
// -----------------------------------------------------------------------------
module mdl_abspgcntr_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/mdl_abspgcntr.sv
// -----------------------------------------------------------------------------
// mdl_abspgcntr
// Bit-serial absolute page counter. A 12-bit circulating shift register holds
// the current absolute page (0..2052); it is shifted out LSB-first during
// ROT20 slots 0-11 and incremented in the same pass when a page-advance
// request was collected in the previous frame. The equivalent relative page
// is produced alongside by a serial adder.
//
// Ports:
//   i_MCLK           master clock
//   i_RST_n          asynchronous active-low reset
//   i_CLK2M_PCEN_n   active-low clock enable; registers move only when 0
//   i_ROT20_n[19:0]  active-low one-hot slot timing
//   i_PGADV          page-advance request
//   o_ABSPGCNTR_LSB  serial absolute page, bit k in slot k
//   o_RELPG_LSB      serial relative page, bit k in slot k
//   o_ABSPG_GTE754   latched flag: stored page >= 754
//   o_ABSPG_ATMAX    latched flag: stored page == 2052
//   o_ABSPG_DBG      parallel copy of the page latched at slot 12
//                    (present only when ABSPGCNTR_DBG_EN is defined)
// -----------------------------------------------------------------------------
module mdl_abspgcntr
    import mdl_abspgcntr_pkg::*;
(
    input  logic             i_MCLK,
    input  logic             i_RST_n,
    input  logic             i_CLK2M_PCEN_n,
    input  logic [ROT_W-1:0] i_ROT20_n,
    input  logic             i_PGADV,
    output logic             o_ABSPGCNTR_LSB,
    output logic             o_RELPG_LSB,
    output logic             o_ABSPG_GTE754,
    output logic             o_ABSPG_ATMAX
`ifdef ABSPGCNTR_DBG_EN
    ,
    output logic [PG_W-1:0]  o_ABSPG_DBG
`endif
);

    // Timing decode.
    logic en;
    logic slot_shift;
    logic slot_latch;
    logic slot_clr;

    assign en         = ~i_CLK2M_PCEN_n;
    assign slot_shift = ~&i_ROT20_n[SLOT_MSB:SLOT_LSB];
    assign slot_latch = ~i_ROT20_n[SLOT_LATCH];
    assign slot_clr   = ~i_ROT20_n[SLOT_CLR];

    // State.
    logic [PG_W-1:0] sr_q,       sr_d;        // circulating page register
    logic            ic_q,       ic_d;        // incrementer carry
    logic            wrap_act_q, wrap_act_d;  // this frame's increment wraps to 0
    logic            inc_pend_q, inc_pend_d;  // request collected during the frame
    logic            ge_q,       ge_d;        // running "new page >= 754"
    logic            ne_q,       ne_d;        // running "new page != 2052"
    logic            gte_q,      gte_d;
    logic            atmax_q,    atmax_d;
    logic            rc_q,       rc_d;        // conversion adder carry

    // Serial datapath.
    logic nb;        // new bit entering the top of sr
    logic req;       // request as seen at this edge
    logic c_gte_k;
    logic c_max_k;
    logic k_bit;
    logic rel_cout;

    assign req     = inc_pend_q | i_PGADV;
    // A wrapping increment only happens from 2052, so forcing every new bit
    // to 0 yields page 0 without a compare on the full word.
    assign nb      = wrap_act_q ? 1'b0 : (sr_q[0] ^ ic_q);
    assign c_gte_k = slot_const_bit(i_ROT20_n, C_GTE);
    assign c_max_k = slot_const_bit(i_ROT20_n, C_MAX);
    // The offset depends on which half of the range the streamed page is in;
    // the flag latched at slot 12 of the previous frame describes exactly the
    // value streaming out now (pre-increment).
    assign k_bit   = slot_const_bit(i_ROT20_n, gte_q ? K_REL_HI : K_REL_LO);

    assign o_ABSPGCNTR_LSB = sr_q[0];
    assign o_ABSPG_GTE754  = gte_q;
    assign o_ABSPG_ATMAX   = atmax_q;

    mdl_abspgcntr_fa u_rel_fa (
        .i_a    (sr_q[0]),
        .i_b    (k_bit),
        .i_cin  (rc_q),
        .o_sum  (o_RELPG_LSB),
        .o_cout (rel_cout)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q before any condition, so no path
        // through this block can leave a signal unassigned and infer a latch.
        sr_d       = sr_q;
        ic_d       = ic_q;
        wrap_act_d = wrap_act_q;
        inc_pend_d = inc_pend_q;
        ge_d       = ge_q;
        ne_d       = ne_q;
        gte_d      = gte_q;
        atmax_d    = atmax_q;
        rc_d       = rc_q;

        if (en) begin
            if (slot_shift) begin
                sr_d = {nb, sr_q[PG_W-1:1]};
                ic_d = sr_q[0] & ic_q;
                // LSB-first magnitude compare: a higher differing bit
                // overrides whatever the lower bits concluded.
                ge_d = (nb & ~c_gte_k) | (~(nb ^ c_gte_k) & ge_q);
                ne_d = ne_q | (nb ^ c_max_k);
                rc_d = rel_cout;
            end

            if (slot_latch) begin
                gte_d   = ge_q;
                atmax_d = ~ne_q;
            end

            if (slot_clr) begin
                ic_d       = req;
                wrap_act_d = req & atmax_q;
                inc_pend_d = 1'b0;
                ge_d       = 1'b1;   // equal so far counts as >=
                ne_d       = 1'b0;
                rc_d       = 1'b0;
            end else begin
                inc_pend_d = inc_pend_q | i_PGADV;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            sr_q       <= '0;
            ic_q       <= 1'b0;
            wrap_act_q <= 1'b0;
            inc_pend_q <= 1'b0;
            ge_q       <= 1'b0;
            ne_q       <= 1'b0;
            gte_q      <= 1'b0;
            atmax_q    <= 1'b0;
            rc_q       <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            ic_q       <= ic_d;
            wrap_act_q <= wrap_act_d;
            inc_pend_q <= inc_pend_d;
            ge_q       <= ge_d;
            ne_q       <= ne_d;
            gte_q      <= gte_d;
            atmax_q    <= atmax_d;
            rc_q       <= rc_d;
        end
    end

`ifdef ABSPGCNTR_DBG_EN
    logic [PG_W-1:0] dbg_q, dbg_d;

    always_comb begin
        dbg_d = dbg_q;
        if (en && slot_latch) begin
            dbg_d = sr_q;
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign o_ABSPG_DBG = dbg_q;
`endif

endmodule

// File: tb/tb_mdl_abspgcntr.sv
// -----------------------------------------------------------------------------
// tb_mdl_abspgcntr
// Randomized bench for mdl_abspgcntr. The stimulus process drives slot
// timing, clock-enable gaps and page-advance strobes, keeps an arithmetic
// model of the page (integer value, pending flag, latched flags) and pushes
// the expected serial bits / flags for each observed slot into a queue. A
// monitor pops and compares on the falling edge of every enabled cycle in
// slots 0-11 (serial bits and flags) and slot 13 (freshly latched flags).
// -----------------------------------------------------------------------------
module tb_mdl_abspgcntr;

    localparam int TB_MAX    = 2052;
    localparam int TB_THRESH = 754;
    localparam int TB_OFS    = 1299;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pcen_n = 1'b1;
    logic [19:0] rot_n  = '1;
    logic        pgadv  = 1'b0;
    logic        abs_lsb;
    logic        rel_lsb;
    logic        gte;
    logic        atmax;
`ifdef ABSPGCNTR_DBG_EN
    logic [11:0] dbg;
`endif

    always #5 clk = ~clk;

    mdl_abspgcntr dut (
        .i_MCLK          (clk),
        .i_RST_n         (rst_n),
        .i_CLK2M_PCEN_n  (pcen_n),
        .i_ROT20_n       (rot_n),
        .i_PGADV         (pgadv),
        .o_ABSPGCNTR_LSB (abs_lsb),
        .o_RELPG_LSB     (rel_lsb),
        .o_ABSPG_GTE754  (gte),
        .o_ABSPG_ATMAX   (atmax)
`ifdef ABSPGCNTR_DBG_EN
        ,
        .o_ABSPG_DBG     (dbg)
`endif
    );

    typedef struct {
        int slot;
        bit abs_b;
        bit rel_b;
        bit gte;
        bit atmax;
        int page;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: page shown during slots 0-11 of the current frame,
    // page after this frame's increment, pending request, latched flags.
    int cur     = 0;
    int nxt     = 0;
    bit pend    = 1'b0;
    bit gte_m   = 1'b0;
    bit atmax_m = 1'b0;

    function automatic int rel_of(input int a);
        return (a >= TB_THRESH) ? a - TB_THRESH : a + TB_OFS;
    endfunction

    function automatic int next_page(input int a);
        return (a == TB_MAX) ? 0 : a + 1;
    endfunction

    function automatic int slot_of(input logic [19:0] r);
        int s;
        s = -1;
        for (int i = 0; i < 20; i++) if (r[i] == 1'b0) s = i;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one queue entry per enabled cycle in slots 0-11 and 13.
    always @(negedge clk) begin : monitor
        int   s;
        exp_t e;
        if (!pcen_n) begin
            s = slot_of(rot_n);
            if ((s >= 0 && s <= 11) || s == 13) begin
                check("sb_entry_available", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("slot_align", s, e.slot);
                    if (s <= 11) begin
                        check($sformatf("abs_bit%0d_pg%0d", s, e.page), abs_lsb, e.abs_b);
                        check($sformatf("rel_bit%0d_pg%0d", s, e.page), rel_lsb, e.rel_b);
                    end
                    check($sformatf("gte754_s%0d_pg%0d", s, e.page), gte, e.gte);
                    check($sformatf("atmax_s%0d_pg%0d", s, e.page), atmax, e.atmax);
`ifdef ABSPGCNTR_DBG_EN
                    if (s == 13) check("dbg_page", dbg, e.page);
`endif
                end
            end
        end
    end

    // Effect of one enabled edge on the model.
    task automatic model_edge(input int s, input bit p);
        if (s == 19) begin
            nxt  = (pend | p) ? next_page(cur) : cur;
            pend = 1'b0;
        end else begin
            pend = pend | p;
        end
        if (s == 11) cur = nxt;
        if (s == 12) begin
            gte_m   = (cur >= TB_THRESH);
            atmax_m = (cur == TB_MAX);
        end
    endtask

    // One slot: a few random disabled cycles (strobe toggling, must be
    // ignored), then one enabled edge.
    task automatic tick(input int s, input bit p, input int gap_pct);
        int   g;
        exp_t e;
        g = 0;
        while (g < 3 && $urandom_range(99) < gap_pct) begin
            pcen_n = 1'b1;
            rot_n  = ~(20'b1 << s);
            pgadv  = 1'($urandom_range(1));
            @(posedge clk); #1;
            g++;
        end
        pcen_n = 1'b0;
        rot_n  = ~(20'b1 << s);
        pgadv  = p;
        if (s <= 11 || s == 13) begin
            e.slot  = s;
            e.abs_b = (s <= 11) ? 1'((cur >> s) & 1) : 1'b0;
            e.rel_b = (s <= 11) ? 1'((rel_of(cur) >> s) & 1) : 1'b0;
            e.gte   = gte_m;
            e.atmax = atmax_m;
            e.page  = cur;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        if (rst_n) model_edge(s, p);
    endtask

    task automatic run_frame(input logic [19:0] adv, input int rnd_pct, input int gap_pct);
        bit p;
        for (int s = 0; s < 20; s++) begin
            p = adv[s] | ($urandom_range(99) < rnd_pct);
            tick(s, p, gap_pct);
        end
    endtask

    // Frame with reset asserted at slot 6 and released before slot 8; a
    // strobe before and during reset must both be lost.
    task automatic reset_frame();
        for (int s = 0; s < 20; s++) begin
            if (s == 6) begin
                rst_n   = 1'b0;
                cur     = 0;
                nxt     = 0;
                pend    = 1'b0;
                gte_m   = 1'b0;
                atmax_m = 1'b0;
                #1;
                check("midrst_abs_lsb", abs_lsb, 0);
                check("midrst_gte754", gte, 0);
                check("midrst_atmax", atmax, 0);
            end
            if (s == 8) rst_n = 1'b1;
            tick(s, (s == 3) || (s == 7), 0);
        end
    endtask

    initial begin
        logic [19:0] m;

        repeat (3) @(posedge clk);
        #1;
        check("reset_abs_lsb", abs_lsb, 0);
        check("reset_rel_lsb", rel_lsb, 0);
        check("reset_gte754", gte, 0);
        check("reset_atmax", atmax, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle frames, then a single strobe in slot 5.
        repeat (3) run_frame('0, 0, 25);
        run_frame(20'h0_0020, 0, 25);
        repeat (2) run_frame('0, 0, 25);

        // Strobes in slots 2, 7 and 19 of one frame: one increment.
        run_frame(20'h8_0084, 0, 25);
        repeat (2) run_frame('0, 0, 25);

        // Random strobe density with enable gaps.
        repeat (40) run_frame('0, 10, 25);

        // Arm an increment, then reset in the middle of the incrementing frame.
        run_frame(20'h0_0400, 0, 0);
        reset_frame();
        repeat (3) run_frame('0, 0, 10);

        // One strobe per frame at a random slot: walk through 754, 2052 and
        // the wrap back to 0.
        for (int i = 0; i < TB_MAX + 1; i++) begin
            m = 20'b1 << $urandom_range(19);
            run_frame(m, 0, 5);
        end
        repeat (3) run_frame('0, 0, 10);

        pcen_n = 1'b1;
        rot_n  = '1;
        pgadv  = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdl_abspgcntr.md
Name: mdl_abspgcntr

Overview:
- Bit-serial absolute page counter for the 005297 bubble controller; source of the absolute-page serial stream that the page comparator consumes.
- Holds the current absolute page (0..2052) in a 12-bit circulating shift register.
- Shifts the page out LSB-first during ROT20 slots 0-11 and increments it with wrap on page-advance strobes.
- Also emits the equivalent relative page serially (abs→rel, inverse of the comparator's rel→abs mapping).

Parameters:
- PGMAX, 2052, highest valid absolute page; wrap point.
- RELOFS, 1299, relative page corresponding to absolute page 0.

Ports:
- i_MCLK  in  1  master clock; all registers clocked here.
- i_RST_n  in  1  reset, asynchronous, active-low.
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active-low; every register updates only on MCLK edges where this is 0.
- i_ROT20_n  in  20  one-hot active-low slot timing; slot k is active when bit k is 0.
- i_PGADV  in  1  page-advance request, sampled on enabled edges.
- o_ABSPGCNTR_LSB  out  1  serial absolute page, bit k during slot k (k=0..11).
- o_RELPG_LSB  out  1  serial relative page, bit k during slot k.
- o_ABSPG_GTE754  out  1  latched flag: stored page ≥ 754.
- o_ABSPG_ATMAX  out  1  latched flag: stored page == PGMAX.

Behaviour:
- Unless stated otherwise, every update below happens on an enabled edge (MCLK rising with i_CLK2M_PCEN_n=0). Nothing changes on other edges.
- Reset: all registers go to 0. Outputs after reset: o_ABSPGCNTR_LSB=0, o_RELPG_LSB=0 in slot 0 (1299 bit0=1 appears once a slot is active with flag 0), o_ABSPG_GTE754=0, o_ABSPG_ATMAX=0.
- Reset deassertion mid-frame is harmless: the all-zero register rotates unchanged and the first increment waits for the next slot 19.
- Shift register sr[11:0]: o_ABSPGCNTR_LSB = sr[0] combinationally. In slots 0-11, sr <= {nb, sr[11:1]}. In slots 12-19, sr holds. After slot 11, sr is aligned again and holds the new value.
- Incrementer: carry register ic. At slot 19, ic <= inc_act_next. In slots 0-11, nb = wrap_act ? 0 : sr[0]^ic, and ic <= sr[0]&ic.
- Request handling:
  - inc_pend <= inc_pend | i_PGADV on all enabled edges except slot 19.
  - At slot 19: inc_act <= inc_pend | i_PGADV; wrap_act <= (inc_pend | i_PGADV) & o_ABSPG_ATMAX; inc_pend <= 0.
  - Several strobes within one frame collapse into a single increment.
  - A strobe arriving during slots 0-11 takes effect in the next frame.
- Flag pipeline:
  - Running comparators run on nb during slots 0-11.
  - ge754: preset to 1 at slot 19; ge <= (nb & ~c754_k) | (~(nb ^ c754_k) & ge).
  - ne2052: cleared at slot 19; ne <= ne | (nb ^ c2052_k).
  - At slot 12: o_ABSPG_GTE754 <= ge and o_ABSPG_ATMAX <= ~ne.
  - Both flags therefore describe the sr contents from slot 12 onward.
- Abs→rel conversion:
  - Serial adder of sr[0] + K + rc; rc is cleared at slot 19 and updates per slot 0-11.
  - K = 1299 (0101_0001_0011) when o_ABSPG_GTE754=0.
  - K = 3342 (1101_0000_1110, i.e. −754 mod 4096) when o_ABSPG_GTE754=1; the carry out of bit 11 is discarded.
  - Constant bit k is decoded from i_ROT20_n[k].
  - o_RELPG_LSB = sum bit (combinational).
  - The output reflects the pre-increment value of the current frame.
- Mapping: abs 0..753 → rel 1299..2052; abs 754..2052 → rel 0..1298.
- Slots 12-19: both serial outputs are don't-care for consumers, but deterministic (sr[0] and the adder with K bit 0).

Optional Feature:
- Macro ABSPGCNTR_DBG_EN.
- Defined: adds output o_ABSPG_DBG[11:0], a parallel copy of sr latched at slot 12, reset 0.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package/include: PGMAX=2052, RELOFS=1299, ABS_GTE_THRESH=754, the 12-bit constants 1299/3342/754/2052, and slot indices SLOT_LSB=0, SLOT_MSB=11, SLOT_LATCH=12, SLOT_CLR=19.
- The serial conversion adder reuses the existing FA cell.
- No further sub-module; incrementer and comparators stay inline.

Test Plan:
- Reset, run 3 frames with no i_PGADV → o_ABSPGCNTR_LSB 0 in slots 0-11; o_RELPG_LSB serial value = 1299; both flags 0.
- One i_PGADV pulse in slot 5 → frame N+1 shifts out 0, frame N+2 shifts out 1; rel reads 1300.
- Pulses in slots 2, 7 and 19 of the same frame → single increment only.
- 753 advances then one more → stored 754; o_ABSPG_GTE754 rises at slot 12 of the incrementing frame; next frame rel = 0.
- 2052 advances → o_ABSPG_ATMAX=1, rel = 1298; one more advance → abs 0, flags 0, rel 1299.
- Assert i_RST_n=0 at slot 6 mid-increment → sr, flags and pending requests clear immediately; after release, count resumes from 0 with no spurious increment.
